// File: rtl/stat_pkg.sv
// rtl/stat_pkg.sv - shared constants for the retired-instruction statistics block
package stat_pkg;

    localparam int STAT_WIDTH = 32;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Clear beats increment, so a clear coinciding with an event leaves zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/exec_stat_counters.sv
// rtl/exec_stat_counters.sv - write-back statistics counters with syscall halt / go resume
module exec_stat_counters
    import stat_pkg::*;
#(
    parameter int WIDTH = STAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic             wb_is_branch,
    input  logic             wb_is_jump,
    input  logic             wb_taken,
    input  logic             wb_halt,
    input  logic             go,
    input  logic             clear,
    output logic [WIDTH-1:0] total,
    output logic [WIDTH-1:0] conditional_jmp,
    output logic [WIDTH-1:0] unconditional_jmp,
    output logic [WIDTH-1:0] successful_conditional_jmp,
    output logic             halted
);

    run_state_t state;
    run_state_t state_next;
    logic       go_d;
    logic       go_rise;
    logic       run;

    assign go_rise = go & ~go_d;
    assign run     = (state == ST_RUN);
    assign halted  = (state == ST_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            go_d  <= 1'b0;
        end else begin
            state <= state_next;
            go_d  <= go;
        end
    end

    // go is only looked at while halted, so a halt in RUN always wins.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (wb_valid && wb_halt) state_next = ST_HALTED;
            ST_HALTED: if (go_rise)             state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    logic inc_total;
    logic inc_cond;
    logic inc_uncond;
    logic inc_taken;

    assign inc_total  = run & wb_valid;
    assign inc_cond   = inc_total & wb_is_branch;
    assign inc_uncond = inc_total & wb_is_jump;
    assign inc_taken  = inc_cond & wb_taken;

    sat_counter #(.WIDTH(WIDTH)) u_total (
        .clk(clk), .rst(rst), .clr(clear), .inc(inc_total), .count(total)
    );

    sat_counter #(.WIDTH(WIDTH)) u_cond (
        .clk(clk), .rst(rst), .clr(clear), .inc(inc_cond), .count(conditional_jmp)
    );

    sat_counter #(.WIDTH(WIDTH)) u_uncond (
        .clk(clk), .rst(rst), .clr(clear), .inc(inc_uncond), .count(unconditional_jmp)
    );

    sat_counter #(.WIDTH(WIDTH)) u_taken (
        .clk(clk), .rst(rst), .clr(clear), .inc(inc_taken), .count(successful_conditional_jmp)
    );

endmodule
